// File: rtl/key_operand_loader.sv
// key_operand_loader
//   Assembles a 32-bit operand from the slide switches using debounced
//   pushbuttons, then offers it downstream with a valid/ready handshake.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   sw[17:0]    raw switches: [15:0] operand field, [17] quick mode, [16] unused
//   key[3:0]    raw pushbuttons, active-low: 0 load-lo, 1 load-hi, 2 commit, 3 clear
//   data        assembled operand
//   data_valid  operand offered downstream (high exactly while in SEND)
//   data_ready  downstream accepts; transfer when data_valid && data_ready
//   loaded      {hi_loaded, lo_loaded}
//   err         one-cycle pulse on a commit rejected for missing halves
//   xfer_count  completed transfers, wraps 255 -> 0
module key_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] sw,
    input  logic [3:0]  key,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [1:0]  loaded,
    output logic        err,
    output logic [7:0]  xfer_count
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        COLLECT,
        SEND
    } state_t;

    state_t      state, state_n;
    logic [3:0]  key_s1, key_s2;
    logic [16:0] sw_s1, sw_s2;          // {quick, operand[15:0]}
    logic [3:0]  key_db, key_db_d;
    logic [3:0]  press;
    logic [CNT_W-1:0] db_cnt [4];

    logic [31:0] data_n;
    logic        lo_flag, hi_flag, lo_n, hi_n;
    logic        err_n;
    logic [7:0]  cnt_n;

    logic        unused_sw;
    assign unused_sw = sw[16];

    // Two-flop synchronizers; keys idle high (released).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            sw_s1  <= {sw[17], sw[15:0]};
            sw_s2  <= sw_s1;
        end
    end

    // Per-key debounce: the counter runs while the synchronized level differs
    // from the accepted level and clears as soon as they agree again, so the
    // level is taken only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            key_db   <= '1;
            key_db_d <= '1;
        end else begin
            key_db_d <= key_db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (key_s2[i] == key_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    key_db[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press event on a debounced falling edge only.
    assign press = key_db_d & ~key_db;

    always_comb begin
        state_n = state;
        data_n  = data;
        lo_n    = lo_flag;
        hi_n    = hi_flag;
        err_n   = 1'b0;
        cnt_n   = xfer_count;
        case (state)
            COLLECT: begin
                if (press[3]) begin
                    data_n = '0;
                    lo_n   = 1'b0;
                    hi_n   = 1'b0;
                end else if (press[2]) begin
                    if (lo_flag && hi_flag) begin
                        state_n = SEND;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    // Lo is applied first so a simultaneous hi load owns [31:16].
                    if (press[0]) begin
                        if (sw_s2[16]) begin
                            data_n = {8'h00, sw_s2[15:0], 8'h00};
                            lo_n   = 1'b1;
                            hi_n   = 1'b1;
                        end else begin
                            data_n[15:0] = sw_s2[15:0];
                            lo_n         = 1'b1;
                        end
                    end
                    if (press[1]) begin
                        data_n[31:16] = sw_s2[15:0];
                        hi_n          = 1'b1;
                    end
                end
            end
            SEND: begin
                // A transfer wins over a coincident clear.
                if (data_ready) begin
                    state_n = COLLECT;
                    lo_n    = 1'b0;
                    hi_n    = 1'b0;
                    cnt_n   = xfer_count + 8'd1;
                end else if (press[3]) begin
                    state_n = COLLECT;
                    data_n  = '0;
                    lo_n    = 1'b0;
                    hi_n    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            data       <= '0;
            lo_flag    <= 1'b0;
            hi_flag    <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_n;
            data       <= data_n;
            lo_flag    <= lo_n;
            hi_flag    <= hi_n;
            err        <= err_n;
            xfer_count <= cnt_n;
        end
    end

    assign data_valid = (state == SEND);
    assign loaded     = {hi_flag, lo_flag};

endmodule

// File: tb/tb_key_operand_loader.sv
module tb_key_operand_loader;

    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] sw = '0;
    logic [3:0]  key = '1;
    logic        data_ready = 1'b0;
    logic [31:0] data;
    logic        data_valid;
    logic [1:0]  loaded;
    logic        err;
    logic [7:0]  xfer_count;

    key_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .key        (key),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .loaded     (loaded),
        .err        (err),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    int vcnt, ecnt, found;
    logic [15:0] v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive and sample 2 time units after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int k);
        key[k] = 1'b0;
        tick(10);
        key[k] = 1'b1;
        tick(10);
    endtask

    // Scoreboard side: every transfer must match the next queued operand.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                assert (0) else begin
                    n_errors++;
                    $error("FAIL unexpected_xfer: observed transfer of %h expected none", data);
                end
            end else begin
                check("xfer_data", data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_data", data, 32'h0);
        check("rst_valid", data_valid, 1'b0);
        check("rst_loaded", loaded, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_count", xfer_count, 8'd0);
        rst_n = 1'b1;
        tick(2);

        // Two-half load, commit, immediate acceptance
        data_ready = 1'b1;
        sw = 18'h01234;
        press(0);
        check("s1_lo_flags", loaded, 2'b01);
        check("s1_lo_data", data[15:0], 16'h1234);
        sw = 18'h0ABCD;
        press(1);
        check("s1_hi_flags", loaded, 2'b11);
        check("s1_full_data", data, 32'hABCD1234);
        exp_q.push_back(32'hABCD1234);
        vcnt = 0;
        key[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (data_valid) vcnt++;
        end
        key[2] = 1'b1;
        tick(10);
        check("s1_valid_cycles", vcnt, 1);
        check("s1_count", xfer_count, 8'd1);
        check("s1_loaded_clr", loaded, 2'b00);
        check("s1_data_kept", data, 32'hABCD1234);

        // Quick mode, offer held under back-pressure
        data_ready = 1'b0;
        sw = {1'b1, 1'b0, 16'h0180};
        press(0);
        check("s2_quick_flags", loaded, 2'b11);
        check("s2_quick_data", data, 32'h00018000);
        press(2);
        for (int i = 0; i < 10; i++) begin
            check("s2_valid_hold", data_valid, 1'b1);
            check("s2_data_hold", data, 32'h00018000);
            tick(1);
        end
        exp_q.push_back(32'h00018000);
        data_ready = 1'b1;
        tick(1);
        check("s2_valid_drop", data_valid, 1'b0);
        check("s2_count", xfer_count, 8'd2);
        check("s2_loaded_clr", loaded, 2'b00);

        // Bouncing key produces exactly one load
        data_ready = 1'b0;
        sw = 18'h05A5A;
        for (int i = 0; i < 10; i++) begin
            key[0] = ~key[0];
            tick(2);
        end
        check("s3_no_bounce_load", loaded, 2'b00);
        key[0] = 1'b0;
        tick(6);
        key[0] = 1'b1;
        tick(12);
        check("s3_loaded", loaded, 2'b01);
        check("s3_data", data, 32'h00015A5A);

        // Rejected commit with only lo loaded
        ecnt = 0;
        vcnt = 0;
        key[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (err) ecnt++;
            if (data_valid) vcnt++;
        end
        key[2] = 1'b1;
        tick(10);
        check("s4_err_cycles", ecnt, 1);
        check("s4_valid_cycles", vcnt, 0);
        check("s4_loaded", loaded, 2'b01);

        // Clear aborts an offer not yet accepted
        sw = 18'h01111;
        press(1);
        check("s5_loaded", loaded, 2'b11);
        check("s5_data", data, 32'h11115A5A);
        press(2);
        check("s5_in_send", data_valid, 1'b1);
        key[3] = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (!data_valid) found = 1;
        end
        check("s5_abort_seen", found, 1);
        check("s5_abort_data", data, 32'h0);
        check("s5_abort_loaded", loaded, 2'b00);
        check("s5_abort_count", xfer_count, 8'd2);
        key[3] = 1'b1;
        tick(10);

        // Counter wrap after 256 transfers in total
        data_ready = 1'b1;
        for (int i = 0; i < 254; i++) begin
            v = 16'(i * 257 + 3);
            sw = {1'b1, 1'b0, v};
            exp_q.push_back({8'h00, v, 8'h00});
            press(0);
            press(2);
            if (i == 252) check("s6_count_255", xfer_count, 8'd255);
        end
        check("s6_count_wrap", xfer_count, 8'd0);
        check("s6_loaded", loaded, 2'b00);

        // Reset in the middle of an offer
        data_ready = 1'b0;
        sw = {1'b1, 1'b0, 16'hBEEF};
        press(0);
        press(2);
        check("s7_in_send", data_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s7_rst_data", data, 32'h0);
        check("s7_rst_valid", data_valid, 1'b0);
        check("s7_rst_loaded", loaded, 2'b00);
        check("s7_rst_err", err, 1'b0);
        check("s7_rst_count", xfer_count, 8'd0);
        tick(2);
        rst_n = 1'b1;
        data_ready = 1'b1;
        tick(10);
        check("s7_post_valid", data_valid, 1'b0);
        check("s7_post_count", xfer_count, 8'd0);
        check("s7_post_data", data, 32'h0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_operand_loader.md
KEY_OPERAND_LOADER -- requirements
Module: key_operand_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles before a key level is accepted (10 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sw  input  18  raw slide switches; sw[15:0] operand field, sw[17] quick mode.
REQ-005 SHALL have port key  input  4  raw pushbuttons, active-low; key[0] load-lo, key[1] load-hi, key[2] commit, key[3] clear.
REQ-006 SHALL have port data  output  32  assembled operand to the downstream sigmoid stage.
REQ-007 SHALL have port data_valid  output  1  operand offered downstream.
REQ-008 SHALL have port data_ready  input  1  downstream accepts; a transfer occurs when data_valid and data_ready are both 1 in one cycle.
REQ-009 SHALL have port loaded  output  2  {hi_loaded, lo_loaded} flags.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a rejected commit.
REQ-011 SHALL have port xfer_count  output  8  count of completed transfers.

Function
REQ-012 SHALL pass key and sw through two-flop synchronizers before use.
REQ-013 SHALL debounce each key independently: the debounced level takes the synchronized value only after that value has been stable for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-014 SHALL generate a one-cycle press event on each debounced 1->0 transition; no event on release.
REQ-015 SHALL implement two states, COLLECT and SEND; data_valid = 1 exactly in SEND.
REQ-016 In COLLECT, load-lo with sw[17]=0 SHALL write data[15:0] <= sw[15:0] and set lo_loaded.
REQ-017 In COLLECT, load-hi SHALL write data[31:16] <= sw[15:0] and set hi_loaded, regardless of sw[17].
REQ-018 In COLLECT, load-lo with sw[17]=1 SHALL write data <= {8'h00, sw[15:0], 8'h00} and set both flags.
REQ-019 In COLLECT, commit with both flags set SHALL move to SEND next cycle.
REQ-020 A commit with either flag clear SHALL stay in COLLECT and pulse err for one cycle.
REQ-021 In COLLECT, clear SHALL zero data and both flags.
REQ-022 Same-cycle event priority SHALL be clear > commit > loads; lower-priority events that cycle are dropped; load-lo and load-hi together both apply.
REQ-023 In SEND, data SHALL be held stable; load and commit events are ignored.
REQ-024 On a transfer, the block SHALL return to COLLECT next cycle with flags cleared, data retained, and xfer_count incremented, wrapping 255->0.
REQ-025 In SEND, clear without data_ready SHALL abort: return to COLLECT, zero data and flags, no increment; clear coinciding with a transfer is ignored and the transfer completes.
REQ-026 From a press at the pins to the data/flag update, latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, with data_valid rising 1 cycle after a commit event.

Reset
REQ-027 rst_n = 0 SHALL immediately force state COLLECT, data = 0, data_valid = 0, loaded = 0, err = 0, xfer_count = 0, debounce counters = 0, and synchronizer and debounced key levels = 1 (released).
REQ-028 Reset asserted mid-debounce or during SEND SHALL discard the pending press or offer; no transfer counts.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Scenario: sw=16'h1234, press key[0]; sw=16'hABCD, press key[1]; press key[2]; data_ready=1 -> data=32'hABCD1234, data_valid high one cycle, xfer_count=1, loaded=0.
REQ-030 Scenario: sw[17]=1, sw[15:0]=16'h0180, press key[0], press key[2], data_ready=0 for 10 cycles -> data=32'h00018000 and data_valid held high and stable for all 10 cycles.
REQ-031 Scenario: key[0] toggles every 2 cycles for 20 cycles, then held low 6 cycles -> exactly one load; lo_loaded=1.
REQ-032 Scenario: only lo loaded, press key[2] -> err pulses for exactly 1 cycle, data_valid stays 0.
REQ-033 Scenario: in SEND, press key[3] with data_ready=0 -> data_valid=0 and data=0 next cycle, xfer_count unchanged.
REQ-034 Scenario: 256 transfers -> xfer_count returns to 0; rst_n pulsed low mid-SEND -> all outputs 0 asynchronously.
